residual_skip_add: RTL and testbench

Parametrised skip-connection merge stage for the residual-block datapath. Buffers the shortcut (skip) tensor in an on-chip FIFO, waits for the matching main-path pixel, and emits the per-channel saturating sum, optionally followed by ReLU, with full valid/ready back-pressure on every port. It sits after the last convolution of a residual block and replaces the fixed-size, valid-only merge of the previous generation. It tracks frame position so downstream layers get an end-of-frame marker.

---
 rtl/residual_pkg.sv | 38 +++
 rtl/residual_skip_fifo.sv | 51 +++++
 rtl/residual_skip_add.sv | 129 ++++++++++++
 tb/tb_residual_skip_add.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/residual_pkg.sv
// Shared types and helpers for the residual skip-connection merge stage:
// FSM state encoding, default-width saturation limits and a generic saturating add.
package residual_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        LAST = 2'd2
    } state_t;

    localparam int unsigned DW_DEFAULT = 32;
    localparam logic signed [DW_DEFAULT-1:0] SAT_MAX = {1'b0, {(DW_DEFAULT-1){1'b1}}};
    localparam logic signed [DW_DEFAULT-1:0] SAT_MIN = {1'b1, {(DW_DEFAULT-1){1'b0}}};

    // Operands arrive sign-extended to SUM_W; the result is clamped to a w-bit
    // signed range and the caller keeps the low w bits.
    localparam int unsigned SUM_W = 64;

    function automatic logic signed [SUM_W-1:0] sat_add(
        input logic signed [SUM_W-1:0] a,
        input logic signed [SUM_W-1:0] b,
        input int unsigned             w
    );
        logic signed [SUM_W:0] s;
        logic signed [SUM_W:0] hi;
        logic signed [SUM_W:0] lo;
        s  = {a[SUM_W-1], a} + {b[SUM_W-1], b};
        hi = $signed((SUM_W+1)'(1) << (w - 1)) - 1;
        lo = ~hi;
        if (s > hi)
            return hi[SUM_W-1:0];
        else if (s < lo)
            return lo[SUM_W-1:0];
        else
            return s[SUM_W-1:0];
    endfunction

endpackage

// File: rtl/residual_skip_fifo.sv
// Synchronous FIFO for buffering shortcut pixels; extra pointer MSB separates full from empty.
module residual_skip_fifo
    import residual_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 64
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_data,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_count = r_wr_ptr - r_rd_ptr;
    assign o_data  = r_mem[r_rd_ptr[AW-1:0]];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push)
            r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/residual_skip_add.sv
// Residual merge: FIFO-buffered skip pixel + main pixel, per-channel saturating add,
// registered output with back-pressure and end-of-frame flag. Optional ReLU: RESIDUAL_SKIP_ADD_RELU_EN.
module residual_skip_add
    import residual_pkg::*;
#(
    parameter int unsigned DATA_WIDHT = 32,
    parameter int unsigned CHANNEL    = 128,
    parameter int unsigned IMG_WIDHT  = 44,
    parameter int unsigned IMG_HEIGHT = 44,
    parameter int unsigned DEPTH      = 64
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [DATA_WIDHT*CHANNEL-1:0]    Skip_Data_In,
    input  logic                             Skip_Valid_In,
    output logic                             Skip_Ready_Out,
    input  logic [DATA_WIDHT*CHANNEL-1:0]    Main_Data_In,
    input  logic                             Main_Valid_In,
    output logic                             Main_Ready_Out,
    output logic [DATA_WIDHT*CHANNEL-1:0]    Data_Out,
    output logic                             Valid_Out,
    input  logic                             Ready_In,
    output logic                             Frame_Done,
    output logic [$clog2(DEPTH):0]           Fill_Level,
    output logic                             Overflow_Err
);

    localparam int unsigned PW       = DATA_WIDHT * CHANNEL;
    localparam int unsigned NPIX     = IMG_WIDHT * IMG_HEIGHT;
    localparam int unsigned CW       = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(NPIX - 1);

    logic [PW-1:0] w_head;
    logic [PW-1:0] w_sum;
    logic          w_full;
    logic          w_empty;
    logic          w_free;
    logic          w_fire;
    logic          w_last;
    logic          w_last_fire;

    logic [PW-1:0] r_data;
    logic          r_valid;
    logic          r_done;
    logic          r_ovf;
    logic [CW-1:0] r_pix;
    state_t        r_state;
    state_t        w_next;

    residual_skip_fifo #(
        .WIDTH (PW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_push  (Skip_Valid_In),
        .i_pop   (w_fire),
        .i_data  (Skip_Data_In),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (Fill_Level)
    );

    assign w_free         = !r_valid || Ready_In;
    assign Main_Ready_Out = !w_empty && w_free;
    assign Skip_Ready_Out = !w_full;
    assign w_fire         = Main_Valid_In && Main_Ready_Out;
    assign w_last         = (r_pix == LAST_IDX);
    assign w_last_fire    = w_fire && w_last;

    assign Data_Out     = r_data;
    assign Valid_Out    = r_valid;
    assign Frame_Done   = r_done;
    assign Overflow_Err = r_ovf;

    always_comb begin
        w_sum = '0;
        for (int unsigned k = 0; k < CHANNEL; k++) begin
            w_sum[k*DATA_WIDHT +: DATA_WIDHT] = DATA_WIDHT'(sat_add(
                SUM_W'($signed(w_head[k*DATA_WIDHT +: DATA_WIDHT])),
                SUM_W'($signed(Main_Data_In[k*DATA_WIDHT +: DATA_WIDHT])),
                DATA_WIDHT));
`ifdef RESIDUAL_SKIP_ADD_RELU_EN
            if (w_sum[k*DATA_WIDHT + DATA_WIDHT - 1])
                w_sum[k*DATA_WIDHT +: DATA_WIDHT] = '0;
`endif
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (w_fire) w_next = w_last_fire ? LAST : RUN;
            RUN:  if (w_last_fire) w_next = LAST;
            LAST: if (r_valid && Ready_In) begin
                      if (w_fire) w_next = w_last_fire ? LAST : RUN;
                      else        w_next = IDLE;
                  end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            r_ovf   <= 1'b0;
            r_pix   <= '0;
        end else begin
            r_state <= w_next;
            if (Skip_Valid_In && w_full)
                r_ovf <= 1'b1;
            if (w_fire) begin
                r_data  <= w_sum;
                r_valid <= 1'b1;
                r_done  <= w_last;
                r_pix   <= w_last ? '0 : r_pix + CW'(1);
            end else if (Ready_In) begin
                // Data_Out keeps its last value after acceptance; only the qualifiers drop.
                r_valid <= 1'b0;
                r_done  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_residual_skip_add.sv
// Self-checking bench for residual_skip_add: directed + random traffic against a queue-based model.
`timescale 1ns/1ps
module tb_residual_skip_add;

    localparam int DW    = 32;
    localparam int CH    = 128;
    localparam int W     = 44;
    localparam int H     = 44;
    localparam int DEPTH = 64;
    localparam int PW    = DW * CH;
    localparam int NPIX  = W * H;

    typedef logic [PW-1:0] pix_t;

    logic       clk = 1'b0;
    logic       rst;
    pix_t       skip_d, main_d, dout;
    logic       skip_v, skip_rdy, main_v, main_rdy, vout, rdy_in, fdone, ovf;
    logic [6:0] fill;

    residual_skip_add #(
        .DATA_WIDHT (DW),
        .CHANNEL    (CH),
        .IMG_WIDHT  (W),
        .IMG_HEIGHT (H),
        .DEPTH      (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .Skip_Data_In   (skip_d),
        .Skip_Valid_In  (skip_v),
        .Skip_Ready_Out (skip_rdy),
        .Main_Data_In   (main_d),
        .Main_Valid_In  (main_v),
        .Main_Ready_Out (main_rdy),
        .Data_Out       (dout),
        .Valid_Out      (vout),
        .Ready_In       (rdy_in),
        .Frame_Done     (fdone),
        .Fill_Level     (fill),
        .Overflow_Err   (ovf)
    );

    always #5 clk = ~clk;

    // Reference model state
    pix_t mq[$];
    pix_t m_data;
    bit   m_valid, m_done, m_ovf;
    int   m_pix;
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_pix(input string tag, input pix_t obs, input pix_t exp);
        int ch;
        total++;
        assert (obs === exp) else begin
            bad++;
            ch = 0;
            for (int k = CH - 1; k >= 0; k--)
                if (obs[k*DW +: DW] !== exp[k*DW +: DW]) ch = k;
            $error("FAIL %s ch%0d observed=%h expected=%h", tag, ch, obs[ch*DW +: DW], exp[ch*DW +: DW]);
        end
    endtask

    function automatic pix_t fill32(input logic [31:0] v);
        pix_t p;
        for (int k = 0; k < CH; k++) p[k*DW +: DW] = v;
        return p;
    endfunction

    function automatic pix_t rnd_pix();
        pix_t p;
        for (int k = 0; k < CH; k++) begin
            case ($urandom_range(0, 3))
                0:       p[k*DW +: DW] = 32'h7FFF_FF00 | 32'($urandom_range(0, 255));
                1:       p[k*DW +: DW] = 32'h8000_0000 | 32'($urandom_range(0, 255));
                default: p[k*DW +: DW] = $urandom;
            endcase
        end
        return p;
    endfunction

    function automatic pix_t ref_sum(input pix_t a, input pix_t b);
        pix_t   r;
        longint s;
        for (int k = 0; k < CH; k++) begin
            s = longint'($signed(a[k*DW +: DW])) + longint'($signed(b[k*DW +: DW]));
            if (s > 64'sd2147483647)  s = 64'sd2147483647;
            if (s < -64'sd2147483648) s = -64'sd2147483648;
`ifdef RESIDUAL_SKIP_ADD_RELU_EN
            if (s < 0) s = 0;
`endif
            r[k*DW +: DW] = s[31:0];
        end
        return r;
    endfunction

    task automatic reset_model();
        mq.delete();
        m_data  = '0;
        m_valid = 1'b0;
        m_done  = 1'b0;
        m_ovf   = 1'b0;
        m_pix   = 0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_valid"}, 64'(vout), 64'd0);
        chk_pix({tag, "_data"}, dout, '0);
        chk({tag, "_done"}, 64'(fdone), 64'd0);
        chk({tag, "_fill"}, 64'(fill), 64'd0);
        chk({tag, "_ovf"}, 64'(ovf), 64'd0);
        chk({tag, "_skip_rdy"}, 64'(skip_rdy), 64'd1);
        chk({tag, "_main_rdy"}, 64'(main_rdy), 64'd0);
    endtask

    // One clock cycle, entered and left at a negedge.
    task automatic cycle(input bit sv, input pix_t sd, input bit mv, input pix_t md, input bit r);
        bit   e_srdy, e_mrdy, push, fire;
        pix_t head;
        skip_v = sv; skip_d = sd; main_v = mv; main_d = md; rdy_in = r;
        #1;
        e_srdy = (mq.size() < DEPTH);
        e_mrdy = (mq.size() > 0) && (!m_valid || r);
        chk("skip_ready", 64'(skip_rdy), 64'(e_srdy));
        chk("main_ready", 64'(main_rdy), 64'(e_mrdy));
        push = sv && e_srdy;
        fire = mv && e_mrdy;
        @(posedge clk);
        if (sv && !e_srdy) m_ovf = 1'b1;
        if (fire) begin
            head    = mq.pop_front();
            m_data  = ref_sum(head, md);
            m_valid = 1'b1;
            m_done  = (m_pix == NPIX - 1);
            m_pix   = (m_pix + 1) % NPIX;
        end else if (r) begin
            m_valid = 1'b0;
            m_done  = 1'b0;
        end
        if (push) mq.push_back(sd);
        @(negedge clk);
        chk("valid_out", 64'(vout), 64'(m_valid));
        chk_pix("data_out", dout, m_data);
        chk("frame_done", 64'(fdone), 64'(m_done));
        chk("fill_level", 64'(fill), 64'(mq.size()));
        chk("overflow", 64'(ovf), 64'(m_ovf));
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, '0, 1'b1);
    endtask

    task automatic frame_traffic(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, rnd_pix(), 1'b1, rnd_pix(), 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        skip_v = 0; main_v = 0; rdy_in = 1; skip_d = '0; main_d = '0;
        rst = 1'b1;
        #2 rst = 1'b0;
        #1 chk_reset_vals("reset");
        reset_model();
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Basic add: 1 + 2 = 3 per channel, one cycle after each fire
        for (int i = 0; i < 3; i++) cycle(1'b1, fill32(32'h1), 1'b0, '0, 1'b1);
        chk("basic_fill3", 64'(fill), 64'd3);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, '0, 1'b1, fill32(32'h2), 1'b1);
            chk_pix("basic_sum", dout, fill32(32'h3));
        end
        chk("basic_fill0", 64'(fill), 64'd0);
        idle_cycles(1);

        // Saturation corners and the negative-sum case
        cycle(1'b1, fill32(32'h7FFF_FFF0), 1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b1, fill32(32'h0000_0100), 1'b1);
        chk_pix("sat_pos", dout, fill32(32'h7FFF_FFFF));
        cycle(1'b1, fill32(32'h8000_0010), 1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b1, fill32(32'hFFFF_FF00), 1'b1);
`ifdef RESIDUAL_SKIP_ADD_RELU_EN
        chk_pix("sat_neg", dout, fill32(32'h0));
`else
        chk_pix("sat_neg", dout, fill32(32'h8000_0000));
`endif
        cycle(1'b1, fill32(32'hFFFF_FFFE), 1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b1, fill32(32'h0000_0001), 1'b1);
`ifdef RESIDUAL_SKIP_ADD_RELU_EN
        chk_pix("neg_one", dout, fill32(32'h0));
`else
        chk_pix("neg_one", dout, fill32(32'hFFFF_FFFF));
`endif
        idle_cycles(1);

        // Back-pressure: Ready_In low for 5 cycles mid-stream
        for (int i = 0; i < 6; i++) cycle(1'b1, rnd_pix(), 1'b0, '0, 1'b1);
        for (int i = 0; i < 2; i++) cycle(1'b0, '0, 1'b1, rnd_pix(), 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b1, rnd_pix(), 1'b0);
        for (int i = 0; i < 6; i++) cycle(1'b0, '0, 1'b1, rnd_pix(), 1'b1);
        chk("stall_drained", 64'(fill), 64'd0);

        // Fill to DEPTH, then one more push sets the sticky overflow
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, rnd_pix(), 1'b0, '0, 1'b1);
        chk("full_fill", 64'(fill), 64'(DEPTH));
        cycle(1'b1, fill32(32'hDEAD_BEEF), 1'b0, '0, 1'b1);
        chk("ovf_set", 64'(ovf), 64'd1);
        chk("full_hold", 64'(fill), 64'(DEPTH));
        for (int i = 0; i < DEPTH + 1; i++) cycle(1'b0, '0, 1'b1, rnd_pix(), 1'b1);

        // Random mixed traffic
        for (int i = 0; i < 300; i++)
            cycle(($urandom_range(0, 1) == 1), rnd_pix(), ($urandom_range(0, 4) != 0), rnd_pix(),
                  ($urandom_range(0, 3) != 0));
        for (int i = 0; i < DEPTH + 2; i++) cycle(1'b0, '0, 1'b1, rnd_pix(), 1'b1);

        // Run past a full frame boundary
        frame_traffic(NPIX + 4);

        // Asynchronous reset mid-frame
        frame_traffic(100);
        #2 rst = 1'b0;
        #1 chk_reset_vals("midreset");
        reset_model();
        @(negedge clk);
        rst = 1'b1;

        // Counter restarts at 0 after reset: Frame_Done on the 1936th fire
        frame_traffic(NPIX + 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
